// File: rtl/gp_cmd_sequencer_pkg.sv
// gp_seq_pkg
// Shared types and constants for the GP command sequencer.
//   seq_state_e  : sequencer FSM states
//   err_code_e   : sequence result codes reported on err_code
//   END_OPCODE   : opcode that terminates a sequence without dispatch
//   get_opcode() : opcode field of an assembled 64-bit command

package gp_seq_pkg;

    localparam int GP_WORD_WIDTH  = 32;
    localparam int GP_ADDR_WIDTH  = 8;
    localparam int GP_CNT_WIDTH   = 8;
    localparam int GP_OPC_WIDTH   = 4;
    localparam int GP_RETRY_LIMIT = 15;

    localparam logic [GP_OPC_WIDTH-1:0] END_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_REQ    = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_DISPATCH  = 3'd3,
        ST_EXEC_WAIT = 3'd4,
        ST_FINISH    = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_EXEC       = 2'd1,
        ERR_RD_TIMEOUT = 2'd2,
        ERR_ABORTED    = 2'd3
    } err_code_e;

    // Opcode sits in the top bits of the hi word.
    function automatic logic [GP_OPC_WIDTH-1:0] get_opcode(
        input logic [2*GP_WORD_WIDTH-1:0] cmd
    );
        return GP_OPC_WIDTH'(cmd >> (2*GP_WORD_WIDTH - GP_OPC_WIDTH));
    endfunction

endpackage

// File: rtl/gp_cmd_word_latch.sv
// gp_cmd_word_latch
// Holds the two buffer words of the command being fetched and presents them
// as one assembled command. The words only change on a read hit, so the
// command stays stable for the whole dispatch handshake.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears both words)
//   lo_we      : capture wr_data as the lo word
//   hi_we      : capture wr_data as the hi word
//   wr_data    : buffer read data
//   cmd        : assembled command {hi, lo}
//   opcode     : opcode field of cmd

module gp_cmd_word_latch #(
    parameter int WORD_WIDTH = 32,
    parameter int OPC_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lo_we,
    input  logic                    hi_we,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    output logic [2*WORD_WIDTH-1:0] cmd,
    output logic [OPC_WIDTH-1:0]    opcode
);

    logic [WORD_WIDTH-1:0] lo_word;
    logic [WORD_WIDTH-1:0] hi_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_word <= '0;
            hi_word <= '0;
        end else begin
            if (lo_we) begin
                lo_word <= wr_data;
            end
            if (hi_we) begin
                hi_word <= wr_data;
            end
        end
    end

    assign cmd    = {hi_word, lo_word};
    assign opcode = hi_word[WORD_WIDTH-1 -: OPC_WIDTH];

endmodule

// File: rtl/gp_cmd_sequencer.sv
// gp_cmd_sequencer
// Walks the command buffer from a base address, fetching two words per
// command, hands each command to the execution unit over valid/ready and
// waits for its completion before fetching the next one. Missed buffer
// reads are re-issued up to a retry limit.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start, base_addr,
//   cmd_count             : sequence request (accepted only when idle)
//   abort                 : abort request pulse
//   rd_en, rd_addr        : buffer read request (one-cycle pulse)
//   rd_valid, rd_data     : buffer read response, one cycle after rd_en
//   exec_valid, exec_cmd,
//   exec_ready            : command handshake to the execution unit
//   exec_done, exec_err   : completion of the accepted command
//   busy, done, err_code,
//   cmd_idx               : sequence status
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | waiting for start
// ST_RD_REQ    | rd_en high, read of ptr+word_sel in flight
// ST_RD_WAIT   | sampling rd_valid; hit stores the word, miss re-issues
// ST_DISPATCH  | END check, then exec_valid held until exec_ready
// ST_EXEC_WAIT | waiting for exec_done of the accepted command
// ST_FINISH    | done pulse, status holds, back to idle

module gp_cmd_sequencer #(
    parameter int WORD_WIDTH  = gp_seq_pkg::GP_WORD_WIDTH,
    parameter int ADDR_WIDTH  = gp_seq_pkg::GP_ADDR_WIDTH,
    parameter int CNT_WIDTH   = gp_seq_pkg::GP_CNT_WIDTH,
    parameter int OPC_WIDTH   = gp_seq_pkg::GP_OPC_WIDTH,
    parameter logic [OPC_WIDTH-1:0] END_OPCODE = gp_seq_pkg::END_OPCODE,
    parameter int RETRY_LIMIT = gp_seq_pkg::GP_RETRY_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    cmd_count,
    input  logic                    abort,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    rd_valid,
    input  logic [WORD_WIDTH-1:0]   rd_data,
    output logic                    exec_valid,
    output logic [2*WORD_WIDTH-1:0] exec_cmd,
    input  logic                    exec_ready,
    input  logic                    exec_done,
    input  logic                    exec_err,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err_code,
    output logic [CNT_WIDTH-1:0]    cmd_idx
);

    import gp_seq_pkg::*;

    localparam int RTY_W = $clog2(RETRY_LIMIT + 1);

    seq_state_e            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  word_sel;
    logic [RTY_W-1:0]      retry_left;
    logic                  abort_pend;

    logic                  abort_now;
    logic [ADDR_WIDTH-1:0] base_even;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  rd_hit;
    logic                  lo_we;
    logic                  hi_we;
    logic [OPC_WIDTH-1:0]  opcode;

    // A same-cycle abort counts as well as one latched earlier, which gives
    // abort priority over rd_valid, exec_done and timeout in that cycle.
    assign abort_now = abort || abort_pend;
    assign base_even = base_addr & ~ADDR_WIDTH'(1);
    assign word_addr = ptr + ADDR_WIDTH'(word_sel);

    assign rd_hit = (state == ST_RD_WAIT) && rd_valid && !abort_now;
    assign lo_we  = rd_hit && !word_sel;
    assign hi_we  = rd_hit && word_sel;

    gp_cmd_word_latch #(
        .WORD_WIDTH (WORD_WIDTH),
        .OPC_WIDTH  (OPC_WIDTH)
    ) u_word_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .lo_we   (lo_we),
        .hi_we   (hi_we),
        .wr_data (rd_data),
        .cmd     (exec_cmd),
        .opcode  (opcode)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            remaining  <= '0;
            word_sel   <= 1'b0;
            retry_left <= '0;
            abort_pend <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            exec_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_OK;
            cmd_idx    <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;

            if (state != ST_IDLE && abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    // Start wins over a same-cycle abort; the abort is dropped.
                    if (start) begin
                        ptr        <= base_even;
                        remaining  <= cmd_count;
                        word_sel   <= 1'b0;
                        cmd_idx    <= '0;
                        err_code   <= ERR_OK;
                        retry_left <= RTY_W'(RETRY_LIMIT);
                        abort_pend <= 1'b0;
                        if (cmd_count == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_RD_REQ;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= base_even;
                        end
                    end
                end

                ST_RD_REQ: begin
                    if (abort_now) begin
                        state    <= ST_FINISH;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_ABORTED;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (abort_now) begin
                        state    <= ST_FINISH;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_ABORTED;
                    end else if (rd_valid) begin
                        retry_left <= RTY_W'(RETRY_LIMIT);
                        if (!word_sel) begin
                            word_sel <= 1'b1;
                            state    <= ST_RD_REQ;
                            rd_en    <= 1'b1;
                            rd_addr  <= ptr + ADDR_WIDTH'(1);
                        end else begin
                            state <= ST_DISPATCH;
                        end
                    end else if (retry_left == RTY_W'(1)) begin
                        // This miss is the RETRY_LIMIT-th in a row.
                        state    <= ST_FINISH;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_RD_TIMEOUT;
                    end else begin
                        retry_left <= retry_left - RTY_W'(1);
                        state      <= ST_RD_REQ;
                        rd_en      <= 1'b1;
                        rd_addr    <= word_addr;
                    end
                end

                ST_DISPATCH: begin
                    // The hi word lands on entry, so the END check happens
                    // here, one cycle before exec_valid can rise.
                    if (!exec_valid) begin
                        if (opcode == END_OPCODE) begin
                            state    <= ST_FINISH;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= abort_now ? ERR_ABORTED : ERR_OK;
                        end else begin
                            exec_valid <= 1'b1;
                        end
                    end else if (exec_ready) begin
                        // A raised exec_valid is never withdrawn; a pending
                        // abort only takes effect once the command is taken.
                        exec_valid <= 1'b0;
                        if (abort_now) begin
                            state    <= ST_FINISH;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_ABORTED;
                        end else begin
                            state <= ST_EXEC_WAIT;
                        end
                    end
                end

                ST_EXEC_WAIT: begin
                    if (abort_now) begin
                        state    <= ST_FINISH;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_ABORTED;
                    end else if (exec_done) begin
                        if (exec_err) begin
                            state    <= ST_FINISH;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_EXEC;
                        end else begin
                            ptr       <= ptr + ADDR_WIDTH'(2);
                            remaining <= remaining - CNT_WIDTH'(1);
                            cmd_idx   <= cmd_idx + CNT_WIDTH'(1);
                            word_sel  <= 1'b0;
                            if (remaining == CNT_WIDTH'(1)) begin
                                state    <= ST_FINISH;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                err_code <= ERR_OK;
                            end else begin
                                state   <= ST_RD_REQ;
                                rd_en   <= 1'b1;
                                rd_addr <= ptr + ADDR_WIDTH'(2);
                            end
                        end
                    end
                end

                ST_FINISH: begin
                    state      <= ST_IDLE;
                    abort_pend <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// Self-checking bench for gp_cmd_sequencer: directed cases plus randomized
// sequences. A sequence-level reference model fills expectation queues for
// read addresses, dispatched commands and the final status; a monitor pops
// and compares whenever the DUT presents the corresponding output.

module tb_gp_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  cmd_count = '0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        exec_valid;
    logic [63:0] exec_cmd;
    logic        exec_ready = 1'b0;
    logic        exec_done = 1'b0;
    logic        exec_err = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [7:0]  cmd_idx;

    gp_cmd_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .cmd_count  (cmd_count),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .exec_valid (exec_valid),
        .exec_cmd   (exec_cmd),
        .exec_ready (exec_ready),
        .exec_done  (exec_done),
        .exec_err   (exec_err),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .cmd_idx    (cmd_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          exp_rd[$];
    logic [63:0] exp_cmd[$];
    logic [9:0]  exp_done[$];   // {err_code, cmd_idx}
    bit          miss_plan[$];  // per read request: 1 = withhold rd_valid
    bit          err_plan[$];   // per accepted command: exec_err on its done
    int          ready_mode = 1; // 0 random, 1 always ready, 2 held low
    int          done_delay = 3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model (sequence level) ----------------
    task automatic model_seq(input logic [7:0] b, input logic [7:0] n);
        int          mi;
        int          ei;
        int          misses;
        logic [7:0]  a;
        logic [31:0] w [2];
        logic [63:0] c;
        bit          m;
        bit          e;
        mi = 0;
        ei = 0;
        if (n == 0) begin
            exp_done.push_back({2'd0, 8'd0});
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 2; k++) begin
                a = 8'((int'(b) & 254) + 2 * i + k);
                misses = 0;
                forever begin
                    exp_rd.push_back(int'(a));
                    m = (mi < miss_plan.size()) ? miss_plan[mi] : 1'b0;
                    mi++;
                    if (!m) break;
                    misses++;
                    if (misses == 15) begin
                        exp_done.push_back({2'd2, 8'(i)});
                        return;
                    end
                end
                w[k] = mem[a];
            end
            c = {w[1], w[0]};
            if (c[63:60] == 4'hF) begin
                exp_done.push_back({2'd0, 8'(i)});
                return;
            end
            exp_cmd.push_back(c);
            e = (ei < err_plan.size()) ? err_plan[ei] : 1'b0;
            ei++;
            if (e) begin
                exp_done.push_back({2'd1, 8'(i)});
                return;
            end
        end
        exp_done.push_back({2'd0, n});
    endtask

    // ---------------- buffer responder ----------------
    bit         rd_pend = 0;
    bit         rd_pend_miss = 0;
    logic [7:0] rd_pend_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_valid = 1'b0;
            rd_pend  = 0;
        end else begin
            rd_valid = rd_pend && !rd_pend_miss;
            rd_data  = (rd_pend && !rd_pend_miss) ? mem[rd_pend_addr] : $urandom;
            rd_pend  = rd_en;
            if (rd_en) begin
                rd_pend_addr = rd_addr;
                rd_pend_miss = (miss_plan.size() > 0) ? miss_plan.pop_front() : 1'b0;
            end
        end
    end

    // ---------------- execution unit ----------------
    int done_cnt = 0;
    bit pend_err = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exec_ready = 1'b0;
            exec_done  = 1'b0;
            exec_err   = 1'b0;
            done_cnt   = 0;
        end else begin
            exec_done = 1'b0;
            exec_err  = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    exec_done = 1'b1;
                    exec_err  = pend_err;
                end
            end
            case (ready_mode)
                0:       exec_ready = 1'($urandom_range(0, 1));
                1:       exec_ready = 1'b1;
                default: exec_ready = 1'b0;
            endcase
            if (exec_valid && exec_ready) begin
                done_cnt = done_delay;
                pend_err = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (rd_en) begin
                if (exp_rd.size() == 0) begin
                    fail($sformatf("unexpected rd_en: addr=0x%0h, none expected", rd_addr));
                end else begin
                    check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
                end
            end
            if (exec_valid && exec_ready) begin
                if (exp_cmd.size() == 0) begin
                    fail($sformatf("unexpected exec handshake: cmd=0x%0h, none expected", exec_cmd));
                end else begin
                    check("exec_cmd", exec_cmd, exp_cmd.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    fail("unexpected done pulse");
                end else begin
                    logic [9:0] d;
                    d = exp_done.pop_front();
                    check("done err_code", 64'(err_code), 64'(d[9:8]));
                    check("done cmd_idx", 64'(cmd_idx), 64'(d[7:0]));
                    check("busy low at done", 64'(busy), 64'(0));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic make_safe(input logic [7:0] lo_addr);
        logic [7:0] h;
        h = lo_addr + 8'd1;
        mem[h][31] = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen;
        seen = 0;
        #3;
        for (int i = 0; i < limit; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #3;
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail({name, ": done not seen within cycle budget"});
    endtask

    task automatic drained(input string name);
        repeat (8) @(negedge clk);
        check({name, ": pending reads"}, 64'(exp_rd.size()), 64'(0));
        check({name, ": pending commands"}, 64'(exp_cmd.size()), 64'(0));
        check({name, ": pending done"}, 64'(exp_done.size()), 64'(0));
        exp_rd.delete();
        exp_cmd.delete();
        exp_done.delete();
        miss_plan.delete();
        err_plan.delete();
    endtask

    task automatic issue_start(input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        cmd_count = n;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 8'($urandom);
        cmd_count = 8'($urandom);
    endtask

    task automatic run_seq(input logic [7:0] b, input logic [7:0] n, input string name);
        model_seq(b, n);
        issue_start(b, n);
        wait_done(3000, name);
        drained(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] held_cmd;
        bit          seen;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        #3;
        check("reset outputs",
              {rd_en, rd_addr, exec_valid, exec_cmd, busy, done, err_code, cmd_idx},
              '0);
        @(negedge clk);
        rst_n = 1'b1;

        // two commands from 0x10
        make_safe(8'h10);
        make_safe(8'h12);
        ready_mode = 1;
        done_delay = 3;
        run_seq(8'h10, 8'd2, "two_cmds");

        // END opcode on the second command
        make_safe(8'h40);
        mem[8'h43][31:28] = 4'hF;
        run_seq(8'h40, 8'd5, "end_opcode");

        // three misses then hit
        make_safe(8'h20);
        for (int i = 0; i < 3; i++) miss_plan.push_back(1'b1);
        run_seq(8'h20, 8'd1, "retry");

        // fifteen misses: timeout
        for (int i = 0; i < 15; i++) miss_plan.push_back(1'b1);
        run_seq(8'h21, 8'd1, "timeout");

        // backpressure with abort
        make_safe(8'h30);
        held_cmd = {mem[8'h31], mem[8'h30]};
        exp_rd.push_back(32'h30);
        exp_rd.push_back(32'h31);
        exp_cmd.push_back(held_cmd);
        exp_done.push_back({2'd3, 8'd0});
        ready_mode = 2;
        issue_start(8'h30, 8'd3);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            if (exec_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("abort: exec_valid never raised");
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                abort = (k == 3);
                #3;
            end
            check($sformatf("backpressure valid cycle %0d", k), 64'(exec_valid), 64'(1));
            check($sformatf("backpressure cmd cycle %0d", k), exec_cmd, held_cmd);
        end
        ready_mode = 1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(50, "abort");
        drained("abort");

        // wrap and exec error
        make_safe(8'hFE);
        make_safe(8'h00);
        err_plan.push_back(1'b0);
        err_plan.push_back(1'b1);
        run_seq(8'hFE, 8'd2, "wrap_exec_err");

        // reset during RD_WAIT
        make_safe(8'h50);
        model_seq(8'h50, 8'd2);
        issue_start(8'h50, 8'd2);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            if (rd_en) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("reset_mid: rd_en not seen");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid outputs",
              {rd_en, rd_addr, exec_valid, exec_cmd, busy, done, err_code, cmd_idx},
              '0);
        exp_rd.delete();
        exp_cmd.delete();
        exp_done.delete();
        miss_plan.delete();
        err_plan.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_done.push_back({2'd0, 8'd0});
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h50;
        cmd_count = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #3;
        check("count0 done next cycle", 64'(done), 64'(1));
        check("count0 no rd_en", 64'(rd_en), 64'(0));
        check("count0 busy", 64'(busy), 64'(0));
        drained("count0");

        // randomized sequences
        for (int it = 0; it < 25; it++) begin
            logic [7:0] b;
            logic [7:0] n;
            b = 8'($urandom);
            n = 8'($urandom_range(0, 6));
            for (int k = 0; k < 40; k++) miss_plan.push_back($urandom_range(0, 3) == 0);
            for (int k = 0; k < 8; k++) err_plan.push_back($urandom_range(0, 9) == 0);
            ready_mode = $urandom_range(0, 1);
            done_delay = $urandom_range(1, 4);
            run_seq(b, n, $sformatf("random_%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gp_cmd_sequencer.md
Name: gp_cmd_sequencer

Overview:
Command fetch/dispatch controller for the GP engine. On a start request it walks the command buffer from a programmed base address. It reads two 32-bit words per command and assembles each 64-bit command. It hands each command to the execution unit over a valid/ready handshake and waits for completion before fetching the next. Dropped buffer reads are retried, since AHB writes take priority inside the buffer. It stops on an END opcode, on reaching the command count, on an error, or on abort.

Parameters:
WORD_WIDTH, 32, width of one buffer word
ADDR_WIDTH, 8, buffer word-address width (256 locations)
CNT_WIDTH, 8, width of the command-count field (max 128 commands used)
OPC_WIDTH, 4, opcode field width, taken from exec_cmd[2*WORD_WIDTH-1 -: OPC_WIDTH]
END_OPCODE, 4'hF, opcode that terminates the sequence without dispatch
RETRY_LIMIT, 15, maximum consecutive missed reads before timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse; accepted only when idle
base_addr  in  ADDR_WIDTH  word address of the first command; bit0 is forced to 0
cmd_count  in  CNT_WIDTH  number of commands to run
abort  in  1  abort request pulse
rd_en  out  1  buffer read request, one-cycle pulse
rd_addr  out  ADDR_WIDTH  buffer read word address; zero-extended to 32 bits at top level
rd_valid  in  1  buffer read data valid, 1 cycle after rd_en
rd_data  in  WORD_WIDTH  buffer read data
exec_valid  out  1  assembled command valid
exec_cmd  out  2*WORD_WIDTH  command {hi_word, lo_word}
exec_ready  in  1  execution unit accepts the command
exec_done  in  1  execution of the accepted command finished (pulse)
exec_err  in  1  error qualifier, sampled with exec_done
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
err_code  out  2  result code: 0 OK, 1 EXEC_ERR, 2 RD_TIMEOUT, 3 ABORTED
cmd_idx  out  CNT_WIDTH  index of the current or last command

Behaviour:
- Reset: all outputs 0; state IDLE; internal pointer, counters and word latches cleared. Reset mid-sequence abandons the sequence with no done pulse.
- State machine: IDLE, RD_REQ, RD_WAIT, DISPATCH, EXEC_WAIT, FINISH.
- IDLE:
  - start: latch ptr={base_addr[ADDR_WIDTH-1:1],0}, remaining=cmd_count, word_sel=0, cmd_idx=0, clear err_code, busy=1, go to RD_REQ.
  - start with cmd_count==0: go to FINISH directly with OK; no reads are issued.
- RD_REQ: rd_en=1 for exactly one cycle, rd_addr=ptr+word_sel (mod 2^ADDR_WIDTH), then go to RD_WAIT.
- RD_WAIT: sample rd_valid in this single cycle.
  - Hit: store rd_data into lo (word_sel=0) or hi (word_sel=1) and clear retry_cnt.
    - After lo: word_sel=1, go to RD_REQ.
    - After hi: go to DISPATCH.
  - Miss: retry_cnt++; re-issue the same address via RD_REQ.
  - Timeout: when retry_cnt reaches RETRY_LIMIT, go to FINISH with RD_TIMEOUT.
  - rd_valid seen in any other state is ignored.
- DISPATCH:
  - If the opcode equals END_OPCODE: go to FINISH with OK; exec_valid is never raised.
  - Otherwise: exec_valid=1 and exec_cmd is driven stably until exec_ready. On exec_valid&&exec_ready, drop exec_valid next cycle and go to EXEC_WAIT. exec_ready asserted in the same cycle exec_valid rises counts as a handshake.
- EXEC_WAIT: wait for exec_done.
  - exec_err=1: go to FINISH with EXEC_ERR.
  - Otherwise: ptr+=2 (wraps mod 2^ADDR_WIDTH), remaining--, cmd_idx++, word_sel=0.
    - remaining==0: go to FINISH with OK.
    - Else: go to RD_REQ.
- Abort:
  - Latched as abort_pend in any non-IDLE state.
  - Takes effect at the next cycle boundary in RD_REQ, RD_WAIT or EXEC_WAIT, going to FINISH with ABORTED.
  - In DISPATCH, exec_valid is never withdrawn; the abort takes effect right after the handshake.
  - Abort has priority over a same-cycle exec_done, rd_valid or timeout.
  - Abort in IDLE is ignored.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. err_code and cmd_idx hold until the next accepted start.
- start while busy: ignored. Simultaneous start and abort in IDLE: start wins and the abort is dropped.
- Throughput: minimum 4 cycles of fetch per command, plus handshake and execution time.

Decomposition:
- Package gp_seq_pkg: state enum seq_state_e; err_code enum (ERR_OK, ERR_EXEC, ERR_RD_TIMEOUT, ERR_ABORTED); END_OPCODE constant; helper function to extract the opcode.
- Sub-module gp_cmd_word_latch: captures the lo/hi words on hit, holds exec_cmd stable, and extracts the opcode. The FSM, pointer, retry counter and status logic stay in the top.

Test Plan:
- Two commands: base=0x10, count=2, buffer returns rd_valid every request, exec_ready=1, exec_done 3 cycles after handshake -> reads at 0x10, 0x11, 0x12, 0x13; two exec handshakes with {mem[0x11],mem[0x10]} and {mem[0x13],mem[0x12]}; done pulse; err_code=0; cmd_idx=2.
- END opcode: count=5, second command hi word has [31:28]=4'hF -> exactly one exec handshake; done; err_code=0; cmd_idx=1.
- Read retry and timeout: rd_valid withheld 3 times at 0x20, then given -> 4 rd_en pulses at 0x20, normal completion. Withheld 15 times -> done with err_code=2, exec_valid never raised.
- Backpressure and abort: exec_ready held low 10 cycles with abort pulsed in cycle 3 -> exec_cmd stable for all 10 cycles; after the handshake FINISH with err_code=3; no further rd_en.
- Exec error and wrap: base=0xFE, count=2 -> second command fetched at 0x00/0x01. exec_err=1 on the second exec_done -> err_code=1, cmd_idx=1.
- Reset mid-sequence: rst_n low during RD_WAIT -> all outputs 0 immediately. Next start with count=0 -> done one cycle later, no rd_en.
